pipe_stall_responder: RTL and testbench

//  Consumer end of the load-use hazard interface. Owns the PC register, the IF/ID

---
 rtl/pipe_stall_responder.sv | 140 ++++++++++++++
 tb/tb_pipe_stall_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stall_responder                                         |
// | Description : Consumer side of the load-use hazard interface. Holds the PC,|
// |               the IF/ID register and the ID/EX control word. Each cycle it |
// |               applies the hazard unit's freeze/hold/bubble requests and    |
// |               the EX-stage branch flush. It also exposes a registered      |
// |               stall summary and a saturating bubble counter for debug.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stall_responder #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          CTRL_W   = 10,
  parameter logic [DATA_W-1:0]    RESET_PC = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_freeze_in,
  input  logic              if_id_stall_in,
  input  logic              ctrl_bubble_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] branch_target_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] if_id_instr_out,
  output logic [DATA_W-1:0] if_id_pc4_out,
  output logic [CTRL_W-1:0] id_ex_ctrl_out,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  bubble_cnt_out
);

  // Debug-visible summary of what the pipeline front end did last cycle.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  // Architectural registers.
  logic [DATA_W-1:0] pc_q,       pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [DATA_W-1:0] if_pc4_q,   if_pc4_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [CNT_W-1:0]  bub_cnt_q,  bub_cnt_d;
  state_t            state_q;

  // Sequential PC increment; wraps naturally modulo 2^DATA_W.
  logic [DATA_W-1:0] pc_plus4;
  // Any hazard request active (only meaningful when no flush is present).
  logic              any_req;
  // Counter already at its ceiling; further bubbles are not counted.
  logic              cnt_full;

  assign pc_plus4 = pc_q + PC_STEP;
  assign any_req  = pc_freeze_in | if_id_stall_in | ctrl_bubble_in;
  assign cnt_full = (bub_cnt_q == {CNT_W{1'b1}});

  // Next-state for the datapath: flush dominates, otherwise each request
  // independently controls its own register.
  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc4_d   = if_pc4_q;
    ex_ctrl_d  = ex_ctrl_q;
    bub_cnt_d  = bub_cnt_q;

    if (flush_in) begin
      // Redirect fetch and squash the younger instructions. The squash
      // itself is not a hazard bubble, so the counter is left alone.
      pc_d       = branch_target_in;
      if_instr_d = '0;
      if_pc4_d   = '0;
      ex_ctrl_d  = '0;
    end else begin
      if (!pc_freeze_in) begin
        pc_d = pc_plus4;
      end

      if (!if_id_stall_in) begin
        if_instr_d = instr_in;
        if_pc4_d   = pc_plus4;
      end

      if (ctrl_bubble_in) begin
        ex_ctrl_d = '0;
        if (!cnt_full) begin
          bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
      end else begin
        ex_ctrl_d = id_ctrl_in;
      end
    end
  end

  // Datapath registers; reset overrides every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc4_q   <= '0;
      ex_ctrl_q  <= '0;
      bub_cnt_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
      ex_ctrl_q  <= ex_ctrl_d;
      bub_cnt_q  <= bub_cnt_d;
    end
  end

  // Status FSM: a registered summary only; nothing in the datapath reads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else if (flush_in) begin
      state_q <= ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   state_q <= any_req ? ST_STALL : ST_RUN;
        ST_STALL: state_q <= any_req ? ST_STALL : ST_RUN;
        ST_FLUSH: state_q <= any_req ? ST_STALL : ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign pc_out          = pc_q;
  assign if_id_instr_out = if_instr_q;
  assign if_id_pc4_out   = if_pc4_q;
  assign id_ex_ctrl_out  = ex_ctrl_q;
  assign state_out       = state_q;
  assign bubble_cnt_out  = bub_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stall_responder                                      |
// | Description : Self-checking bench for pipe_stall_responder. It runs the    |
// |               directed scenarios and then random traffic, and compares     |
// |               against a cycle-level behavioural model.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stall_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_freeze_in, if_id_stall_in, ctrl_bubble_in, flush_in;
  logic [31:0] branch_target_in, instr_in;
  logic [9:0]  id_ctrl_in;

  logic [31:0] pc_out, if_id_instr_out, if_id_pc4_out;
  logic [9:0]  id_ex_ctrl_out;
  logic [1:0]  state_out;
  logic [15:0] bubble_cnt_out;

  // Second instance with a tiny counter to exercise saturation.
  logic [31:0] pc_out2, if_id_instr_out2, if_id_pc4_out2;
  logic [9:0]  id_ex_ctrl_out2;
  logic [1:0]  state_out2;
  logic [1:0]  bubble_cnt_out2;

  always #5 clk = ~clk;

  pipe_stall_responder #(.DATA_W(32), .CTRL_W(10), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .pc_freeze_in(pc_freeze_in), .if_id_stall_in(if_id_stall_in),
    .ctrl_bubble_in(ctrl_bubble_in), .flush_in(flush_in),
    .branch_target_in(branch_target_in), .instr_in(instr_in), .id_ctrl_in(id_ctrl_in),
    .pc_out(pc_out), .if_id_instr_out(if_id_instr_out), .if_id_pc4_out(if_id_pc4_out),
    .id_ex_ctrl_out(id_ex_ctrl_out), .state_out(state_out), .bubble_cnt_out(bubble_cnt_out)
  );

  pipe_stall_responder #(.DATA_W(32), .CTRL_W(10), .RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .pc_freeze_in(pc_freeze_in), .if_id_stall_in(if_id_stall_in),
    .ctrl_bubble_in(ctrl_bubble_in), .flush_in(flush_in),
    .branch_target_in(branch_target_in), .instr_in(instr_in), .id_ctrl_in(id_ctrl_in),
    .pc_out(pc_out2), .if_id_instr_out(if_id_instr_out2), .if_id_pc4_out(if_id_pc4_out2),
    .id_ex_ctrl_out(id_ex_ctrl_out2), .state_out(state_out2), .bubble_cnt_out(bubble_cnt_out2)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: architectural values plus an unbounded bubble tally.
  logic [31:0] m_pc, m_ir, m_pc4;
  logic [9:0]  m_ctrl;
  int          m_state;
  longint      m_bubbles;
  logic [31:0] last_instr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint top);
    return (v > top) ? top : v;
  endfunction

  // Apply one cycle of inputs, advance the model by the documented rules,
  // then compare both instances against it.
  task automatic step(input logic r, input logic fz, input logic st, input logic bb,
                      input logic fl, input logic [31:0] tgt);
    logic [31:0] seq_pc;
    reset            = r;
    pc_freeze_in     = fz;
    if_id_stall_in   = st;
    ctrl_bubble_in   = bb;
    flush_in         = fl;
    branch_target_in = tgt;
    instr_in         = $urandom;
    id_ctrl_in       = 10'($urandom);
    @(posedge clk);
    #1;
    seq_pc = m_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0; m_ir = 32'h0; m_pc4 = 32'h0; m_ctrl = '0; m_state = 0; m_bubbles = 0;
    end else if (fl) begin
      m_pc = tgt; m_ir = 32'h0; m_pc4 = 32'h0; m_ctrl = '0; m_state = 2;
    end else begin
      if (!st) begin
        m_ir  = instr_in;
        m_pc4 = seq_pc;
      end
      if (!fz) m_pc = seq_pc;
      m_ctrl = bb ? 10'd0 : id_ctrl_in;
      if (bb) m_bubbles++;
      m_state = (fz || st || bb) ? 1 : 0;
    end
    last_instr = instr_in;
    check("pc",    64'(pc_out),          64'(m_pc));
    check("ir",    64'(if_id_instr_out), 64'(m_ir));
    check("pc4",   64'(if_id_pc4_out),   64'(m_pc4));
    check("ctrl",  64'(id_ex_ctrl_out),  64'(m_ctrl));
    check("state", 64'(state_out),       64'(m_state));
    check("cnt",   64'(bubble_cnt_out),  64'(sat(m_bubbles, 65535)));
    check("pc_b",  64'(pc_out2),         64'(m_pc));
    check("st_b",  64'(state_out2),      64'(m_state));
    check("cnt_b", 64'(bubble_cnt_out2), 64'(sat(m_bubbles, 3)));
  endtask

  initial begin
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    m_pc = '0; m_ir = '0; m_pc4 = '0; m_ctrl = '0; m_state = 0; m_bubbles = 0; last_instr = '0;

    // Reset for two cycles, then free-run fetch.
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    check("rst_pc",    64'(pc_out), 64'h0);
    check("rst_state", 64'(state_out), 64'h0);
    check("rst_cnt",   64'(bubble_cnt_out), 64'h0);
    check("rst_ir",    64'(if_id_instr_out), 64'h0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 32'h0);
      check("run_pc", 64'(pc_out), 64'(i * 4));
      check("run_ir", 64'(if_id_instr_out), 64'(last_instr));
    end

    // Load-use: all three requests for one cycle at pc=0x10.
    step(0, 1, 1, 1, 0, 32'h0);
    check("lu_pc",    64'(pc_out), 64'h10);
    check("lu_ctrl",  64'(id_ex_ctrl_out), 64'h0);
    check("lu_state", 64'(state_out), 64'd1);
    step(0, 0, 0, 0, 0, 32'h0);
    check("lu_pc2",    64'(pc_out), 64'h14);
    check("lu_state2", 64'(state_out), 64'd0);
    check("lu_cnt",    64'(bubble_cnt_out), 64'd1);

    // Flush beats simultaneous stall requests.
    step(0, 1, 1, 1, 1, 32'h400);
    check("fl_pc",    64'(pc_out), 64'h400);
    check("fl_ir",    64'(if_id_instr_out), 64'h0);
    check("fl_state", 64'(state_out), 64'd2);
    check("fl_cnt",   64'(bubble_cnt_out), 64'd1);
    step(0, 0, 0, 0, 0, 32'h0);
    check("fl_state2", 64'(state_out), 64'd0);
    // Back-to-back flushes remain in FLUSH.
    step(0, 0, 0, 0, 1, 32'h800);
    step(0, 0, 0, 0, 1, 32'hC00);
    check("fl_b2b", 64'(state_out), 64'd2);

    // PC wraps from the top of the address space.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 32'h0);
    check("wrap_pc",  64'(pc_out), 64'h0);
    check("wrap_pc4", 64'(if_id_pc4_out), 64'h0);

    // Saturation of the 2-bit counter.
    step(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 32'h0);
      check("sat_cnt", 64'(bubble_cnt_out2), 64'(exp_sat[i]));
    end

    // Reset in the middle of a stall.
    step(1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0);
    check("ms_pc",    64'(pc_out), 64'h20);
    check("ms_state", 64'(state_out), 64'd1);
    step(1, 1, 1, 1, 0, 32'h0);
    check("ms_rpc",   64'(pc_out), 64'h0);
    check("ms_rst",   64'(state_out), 64'd0);
    check("ms_rctrl", 64'(id_ex_ctrl_out), 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
